// File: rtl/prog_launcher_pkg.sv
// Shared definitions for the prog_launcher launch sequencer: FSM state type,
// machine-word width and the all-ones "done" instruction encoding.
package prog_launcher_pkg;

    localparam int kINSTR_W = 9;
    localparam logic [kINSTR_W-1:0] kDONE_INSTR = 9'h1FF;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_e;

endpackage

// File: rtl/prog_launcher_sat_counter.sv
// Width-parameterised up-counter with synchronous clear and enable that
// sticks at all-ones instead of wrapping.
module prog_launcher_sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/prog_launcher.sv
// Host-side launch sequencer: streams a program into instruction memory, pulses
// Start, and times the run until Ack. Optional RUN watchdog: PROG_LAUNCHER_WATCHDOG_EN.
module prog_launcher
    import prog_launcher_pkg::*;
#(
    parameter int AW         = 10,
    parameter int START_CYC  = 2,
    parameter int CW         = 32,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                InValid,
    output logic                InReady,
    input  logic [kINSTR_W-1:0] InData,
    input  logic                InLast,
    output logic                ImemWrEn,
    output logic [AW-1:0]       ImemWrAddr,
    output logic [kINSTR_W-1:0] ImemWrData,
    output logic                Start,
    input  logic                Ack,
    input  logic                Restart,
    output logic                Done,
    output logic                Error,
    output logic [AW:0]         ProgLen,
    output logic [CW-1:0]       CycleCount
);

    localparam int kTW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    state_e                r_state;
    logic                  r_wr_en;
    logic [AW-1:0]         r_wr_addr;
    logic [kINSTR_W-1:0]   r_wr_data;
    logic                  r_done;
    logic                  r_error;
    logic [AW:0]           r_prog_len;

    logic [kTW-1:0]        w_timer;
    logic [CW-1:0]         w_cycle_count;
    logic                  w_in_load;
    logic                  w_in_launch;
    logic                  w_in_run;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_restart;
    logic                  w_launch_end;
    logic                  w_count_en;
    logic                  w_wdog_hit;

    assign w_in_load    = (r_state == LOAD);
    assign w_in_launch  = (r_state == LAUNCH);
    assign w_in_run     = (r_state == RUN);
    assign w_accept     = InValid && w_in_load;
    // Top bit of the length set means every address has been written once.
    assign w_full       = r_prog_len[AW];
    assign w_restart    = Restart && ((r_state == DONE) || (r_state == ERR));
    assign w_launch_end = (w_timer == kTW'(START_CYC - 1));
    assign w_count_en   = w_in_run && !Ack;

`ifdef PROG_LAUNCHER_WATCHDOG_EN
    // Fires on the edge that counts the last allowed cycle, so the count
    // settles exactly at the limit as the FSM leaves RUN.
    assign w_wdog_hit = (w_cycle_count == CW'(WDOG_LIMIT - 1));
`else
    localparam int unused_wdog_limit = WDOG_LIMIT;
    assign w_wdog_hit = 1'b0;
`endif

    prog_launcher_sat_counter #(.W(kTW)) u_launch_timer (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_clr   (!w_in_launch),
        .i_en    (w_in_launch),
        .o_cnt   (w_timer)
    );

    prog_launcher_sat_counter #(.W(CW)) u_cycle_counter (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_clr   (w_restart),
        .i_en    (w_count_en),
        .o_cnt   (w_cycle_count)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= LOAD;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_prog_len <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        if (w_full) begin
                            r_error <= 1'b1;
                            r_state <= ERR;
                        end else begin
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_prog_len[AW-1:0];
                            r_wr_data  <= InData;
                            r_prog_len <= r_prog_len + (AW+1)'(1);
                            if (InLast) begin
                                r_state <= LAUNCH;
                            end
                        end
                    end
                end
                LAUNCH: begin
                    if (w_launch_end) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (Ack) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_wdog_hit) begin
                        r_error <= 1'b1;
                        r_state <= ERR;
                    end
                end
                DONE, ERR: begin
                    if (Restart) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_prog_len <= '0;
                        r_state    <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // Handshake and Start depend on the state register only, never on InValid.
    assign InReady    = w_in_load;
    assign Start      = !w_in_run;
    assign ImemWrEn   = r_wr_en;
    assign ImemWrAddr = r_wr_addr;
    assign ImemWrData = r_wr_data;
    assign Done       = r_done;
    assign Error      = r_error;
    assign ProgLen    = r_prog_len;
    assign CycleCount = w_cycle_count;

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher: random programs and run lengths
// compared against an expected-behaviour model of writes, lengths and timing.
module tb_prog_launcher;
    import prog_launcher_pkg::*;

    localparam int START_CYC = 2;
    localparam int WDOG      = 10;
`ifdef PROG_LAUNCHER_WATCHDOG_EN
    localparam int DMAX = 8;
`else
    localparam int DMAX = 40;
`endif

    typedef logic [8:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, wr_en, start, ack, restart, done, error;
    logic [8:0]  in_data, wr_data;
    logic [9:0]  wr_addr;
    logic [10:0] prog_len;
    logic [31:0] cycle_count;

    logic        s_in_valid, s_in_ready, s_in_last, s_wr_en, s_start, s_ack, s_restart, s_done, s_error;
    logic [8:0]  s_in_data, s_wr_data;
    logic [1:0]  s_wr_addr;
    logic [2:0]  s_prog_len;
    logic [31:0] s_cycle_count;

    always #5 clk = ~clk;

    prog_launcher #(.AW(10), .START_CYC(START_CYC), .CW(32), .WDOG_LIMIT(WDOG)) dut (
        .Clk(clk), .Reset_n(rst_n), .InValid(in_valid), .InReady(in_ready),
        .InData(in_data), .InLast(in_last), .ImemWrEn(wr_en), .ImemWrAddr(wr_addr),
        .ImemWrData(wr_data), .Start(start), .Ack(ack), .Restart(restart),
        .Done(done), .Error(error), .ProgLen(prog_len), .CycleCount(cycle_count)
    );

    prog_launcher #(.AW(2), .START_CYC(START_CYC), .CW(32), .WDOG_LIMIT(WDOG)) dut_s (
        .Clk(clk), .Reset_n(rst_n), .InValid(s_in_valid), .InReady(s_in_ready),
        .InData(s_in_data), .InLast(s_in_last), .ImemWrEn(s_wr_en), .ImemWrAddr(s_wr_addr),
        .ImemWrData(s_wr_data), .Start(s_start), .Ack(s_ack), .Restart(s_restart),
        .Done(s_done), .Error(s_error), .ProgLen(s_prog_len), .CycleCount(s_cycle_count)
    );

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int fall_cyc = -1;

    logic [9:0] obs_addr[$];
    logic [8:0] obs_data[$];
    int         obs_wcyc[$];
    int         acc_edge[$];
    logic [1:0] s_addr[$];
    logic [8:0] s_data[$];

    // Edge k opens "cycle k"; values sampled at edge k belong to cycle k-1.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (wr_en === 1'b1) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            obs_wcyc.push_back(edge_n - 1);
        end
        if (rst_n && in_valid && in_ready) acc_edge.push_back(edge_n);
        if (rst_n && start === 1'b0 && fall_cyc < 0) fall_cyc = edge_n - 1;
        if (s_wr_en === 1'b1) begin
            s_addr.push_back(s_wr_addr);
            s_data.push_back(s_wr_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_wcyc.delete(); acc_edge.delete();
        s_addr.delete(); s_data.delete();
        fall_cyc = -1;
    endtask

    function automatic word_q_t rand_prog(input int len);
        word_q_t q;
        for (int i = 0; i < len; i++) q.push_back(9'($urandom_range(511, 0)));
        return q;
    endfunction

    task automatic load_program(input word_q_t words, input int max_gap, input bit noise);
        for (int i = 0; i < words.size(); i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                ack      = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                restart  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = words[i];
            in_last  = (i == words.size() - 1);
            ack      = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            restart  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        restart  = 1'b0;
        if (noise) begin
            ack = 1'b1;
            @(negedge clk);
        end
        ack = 1'b0;
    endtask

    task automatic run_core(input int d, input bit noise);
        int n;
        n = 0;
        while (start !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (start !== 1'b0) begin
            bad++;
            $display("FAIL run_entry got start=%b exp start=0", start);
            return;
        end
        for (int k = 0; k < d; k++) begin
            restart = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            @(negedge clk);
        end
        restart = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic check_result(input word_q_t words, input int d, input string tag);
        int n, bi, last;
        n = words.size();
        total++;
        if (obs_addr.size() != n) begin
            bad++;
            $display("FAIL %s write_count got=%0d exp=%0d", tag, obs_addr.size(), n);
        end
        bi = -1;
        for (int i = 0; i < n && i < obs_addr.size(); i++)
            if (bi < 0 && (obs_addr[i] !== 10'(i) || obs_data[i] !== words[i])) bi = i;
        total++;
        if (bi >= 0) begin
            bad++;
            $display("FAIL %s write_contents idx=%0d got=%0h:%0h exp=%0h:%0h",
                     tag, bi, obs_addr[bi], obs_data[bi], bi, words[bi]);
        end
        bi = (acc_edge.size() != n) ? n : -1;
        for (int i = 0; i < n && i < obs_wcyc.size() && i < acc_edge.size(); i++)
            if (bi < 0 && obs_wcyc[i] != acc_edge[i]) bi = i;
        total++;
        if (bi >= 0) begin
            bad++;
            $display("FAIL %s write_latency idx=%0d accepts=%0d writes=%0d exp accepts=%0d and write cycle == accept edge",
                     tag, bi, acc_edge.size(), obs_wcyc.size(), n);
        end
        last = (acc_edge.size() > 0) ? acc_edge[acc_edge.size() - 1] : -100;
        total++;
        if (fall_cyc - last != START_CYC) begin
            bad++;
            $display("FAIL %s launch_len got=%0d exp=%0d", tag, fall_cyc - last, START_CYC);
        end
        total++;
        if (prog_len !== 11'(n)) begin
            bad++;
            $display("FAIL %s prog_len got=%0d exp=%0d", tag, prog_len, n);
        end
        total++;
        if (cycle_count !== 32'(d)) begin
            bad++;
            $display("FAIL %s cycle_count got=%0d exp=%0d", tag, cycle_count, d);
        end
        total++;
        if (done !== 1'b1 || error !== 1'b0 || start !== 1'b1) begin
            bad++;
            $display("FAIL %s done_flags got done=%b error=%b start=%b exp 1 0 1", tag, done, error, start);
        end
    endtask

    task automatic restart_and_check(input string tag);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        total++;
        if (prog_len !== '0 || cycle_count !== '0 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s restart got len=%0d cnt=%0d done=%b err=%b rdy=%b exp 0 0 0 0 1",
                     tag, prog_len, cycle_count, done, error, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_data = 0; in_last = 0; ack = 0; restart = 0;
        s_in_valid = 0; s_in_data = 0; s_in_last = 0; s_ack = 0; s_restart = 0;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || start !== 1'b1) begin
            bad++;
            $display("FAIL reset_handshake got rdy=%b start=%b exp 1 1", in_ready, start);
        end
        total++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
            bad++;
            $display("FAIL reset_write got en=%b addr=%0h data=%0h exp 0 0 0", wr_en, wr_addr, wr_data);
        end
        total++;
        if (done !== 1'b0 || error !== 1'b0 || prog_len !== '0 || cycle_count !== '0) begin
            bad++;
            $display("FAIL reset_status got done=%b err=%b len=%0d cnt=%0d exp 0 0 0 0",
                     done, error, prog_len, cycle_count);
        end
        total++;
        if (s_in_ready !== 1'b1 || s_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_small got rdy=%b err=%b exp 1 0", s_in_ready, s_error);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        word_q_t w;
        w = '{9'h012, 9'h034, kDONE_INSTR};
        clear_obs();
        load_program(w, 0, 1'b0);
        run_core(5, 1'b0);
        check_result(w, 5, "directed");
        restart_and_check("directed");
    endtask

    task automatic test_gapped();
        for (int it = 0; it < 6; it++) begin
            word_q_t w;
            int d;
            w = rand_prog(int'($urandom_range(12, 1)));
            d = int'($urandom_range(DMAX, 0));
            clear_obs();
            load_program(w, (it == 0) ? 1 : 2, 1'b0);
            run_core(d, 1'b0);
            check_result(w, d, "gapped");
            restart_and_check("gapped");
        end
    endtask

    task automatic test_ack_ignored();
        for (int it = 0; it < 3; it++) begin
            word_q_t w;
            int d;
            w = rand_prog(int'($urandom_range(6, 2)));
            d = int'($urandom_range(DMAX, 0));
            clear_obs();
            load_program(w, 1, 1'b1);
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL ack_before_run got done=%b exp=0", done);
            end
            run_core(d, 1'b1);
            check_result(w, d, "ack_ignored");
            restart_and_check("ack_ignored");
        end
    endtask

    task automatic test_reset_mid_run();
        word_q_t w;
        int n, d;
        w = rand_prog(4);
        clear_obs();
        load_program(w, 0, 1'b0);
        n = 0;
        while (start !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        repeat (7) @(negedge clk);
        total++;
        if (cycle_count !== 32'd7) begin
            bad++;
            $display("FAIL midrun_count got=%0d exp=7", cycle_count);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (cycle_count !== '0 || start !== 1'b1 || in_ready !== 1'b1 || prog_len !== '0 || wr_en !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset got cnt=%0d start=%b rdy=%b len=%0d wen=%b exp 0 1 1 0 0",
                     cycle_count, start, in_ready, prog_len, wr_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        w = rand_prog(5);
        d = int'($urandom_range(DMAX, 0));
        clear_obs();
        load_program(w, 1, 1'b0);
        run_core(d, 1'b0);
        check_result(w, d, "reload");
        restart_and_check("reload");
    endtask

    task automatic test_overflow();
        word_q_t w;
        int n, bi;
        w = rand_prog(5);
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = w[i];
            s_in_last  = 1'b0;
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        total++;
        if (s_error !== 1'b1 || s_in_ready !== 1'b0 || s_start !== 1'b1 || s_done !== 1'b0 || s_prog_len !== 3'd4) begin
            bad++;
            $display("FAIL overflow_state got err=%b rdy=%b start=%b done=%b len=%0d exp 1 0 1 0 4",
                     s_error, s_in_ready, s_start, s_done, s_prog_len);
        end
        @(negedge clk);
        bi = (s_addr.size() != 4) ? 4 : -1;
        for (int i = 0; i < 4 && i < s_addr.size(); i++)
            if (bi < 0 && (s_addr[i] !== 2'(i) || s_data[i] !== w[i])) bi = i;
        total++;
        if (bi >= 0) begin
            bad++;
            $display("FAIL overflow_writes idx=%0d got count=%0d exp count=4 addr 0..3 data match", bi, s_addr.size());
        end
        s_restart = 1'b1;
        @(negedge clk);
        s_restart = 1'b0;
        total++;
        if (s_prog_len !== '0 || s_error !== 1'b0 || s_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL overflow_restart got len=%0d err=%b rdy=%b exp 0 0 1", s_prog_len, s_error, s_in_ready);
        end
        w = rand_prog(4);
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = w[i];
            s_in_last  = (i == 3);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        total++;
        if (s_error !== 1'b0 || s_prog_len !== 3'd4 || s_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_last got err=%b len=%0d rdy=%b exp 0 4 0", s_error, s_prog_len, s_in_ready);
        end
        n = 0;
        while (s_start !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        total++;
        if (s_done !== 1'b1 || s_addr.size() != 4 || s_cycle_count !== '0) begin
            bad++;
            $display("FAIL full_run got done=%b writes=%0d cnt=%0d exp 1 4 0", s_done, s_addr.size(), s_cycle_count);
        end
        s_restart = 1'b1;
        @(negedge clk);
        s_restart = 1'b0;
    endtask

`ifdef PROG_LAUNCHER_WATCHDOG_EN
    task automatic test_watchdog();
        word_q_t w;
        int n;
        w = rand_prog(3);
        clear_obs();
        load_program(w, 0, 1'b0);
        n = 0;
        while (start !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        repeat (WDOG + 5) @(negedge clk);
        total++;
        if (error !== 1'b1 || cycle_count !== 32'(WDOG) || done !== 1'b0 || start !== 1'b1) begin
            bad++;
            $display("FAIL watchdog got err=%b cnt=%0d done=%b start=%b exp 1 %0d 0 1",
                     error, cycle_count, done, start, WDOG);
        end
        restart_and_check("watchdog");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_gapped();
        test_ack_ignored();
        test_reset_mid_run();
        test_overflow();
`ifdef PROG_LAUNCHER_WATCHDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
